lead_one_scan: RTL and testbench



---
 rtl/lead_one_scan.sv | 197 +++++++++++++++++++
 tb/tb_lead_one_scan.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lead_one_scan.sv
// lead_one_scan: multi-cycle leading/trailing one finder.
// The operand is examined STEP bits per cycle, starting at the MSB
// (dir=1) or at the LSB (dir=0). The scan stops at the first chunk that
// contains a set bit and reports the absolute index of the highest or
// lowest set bit in that chunk.
// Optional feature: define LEAD_ONE_SCAN_NORM_EN to add the norm_out port.
// norm_out holds the operand shifted so that the found bit lands on the
// MSB (dir=1) or on the LSB (dir=0).
module lead_one_scan #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           din,
  input  logic                       dir,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH)-1:0]   pos,
  output logic                       zero
`ifdef LEAD_ONE_SCAN_NORM_EN
  ,
  output logic [WIDTH-1:0]           norm_out
`endif
);

  localparam int NCHUNK = WIDTH / STEP;
  localparam int PW     = $clog2(WIDTH);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] data;
  logic             dir_r;

  logic [PW-1:0]    base_s;
  logic [STEP-1:0]  chunk_s;
  logic             hit_s;
  logic [PW-1:0]    idx_s;
  logic [PW-1:0]    hit_pos_s;
  logic             last_s;

  // Index of the highest set bit in a chunk. The last match in an upward
  // loop wins, so higher bits override lower ones.
  function automatic logic [PW-1:0] hi_index(input logic [STEP-1:0] c);
    logic [PW-1:0] r;
    r = {PW{1'b0}};
    for (int i = 0; i < STEP; i++) begin
      if (c[i]) begin
        r = PW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Index of the lowest set bit in a chunk. The last match in a downward
  // loop wins, so lower bits override higher ones.
  function automatic logic [PW-1:0] lo_index(input logic [STEP-1:0] c);
    logic [PW-1:0] r;
    r = {PW{1'b0}};
    for (int i = STEP - 1; i >= 0; i--) begin
      if (c[i]) begin
        r = PW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Select chunk k in scan order and locate its first set bit in scan order.
  always_comb begin
    if (dir_r) begin
      base_s = PW'(WIDTH - STEP * (int'(k) + 1));
    end else begin
      base_s = PW'(STEP * int'(k));
    end
    chunk_s = STEP'(data >> base_s);
    hit_s   = |chunk_s;
    if (dir_r) begin
      idx_s = hi_index(chunk_s);
    end else begin
      idx_s = lo_index(chunk_s);
    end
    hit_pos_s = base_s + idx_s;
    last_s    = (int'(k) == NCHUNK - 1);
  end

  // Control FSM: state, chunk counter, and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k     <= {KW{1'b0}};
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SCAN;
            k     <= {KW{1'b0}};
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
          done <= 1'b0;
        end
        ST_SCAN: begin
          if (hit_s || last_s) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            k     <= k + KW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          k     <= {KW{1'b0}};
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Capture the operand and direction when a request is accepted, so that
  // later changes on din/dir cannot disturb the scan in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= {WIDTH{1'b0}};
      dir_r <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      data  <= din;
      dir_r <= dir;
    end else begin
      data  <= data;
      dir_r <= dir_r;
    end
  end

  // Result registers. These are written only when the scan finishes and
  // hold their value through IDLE until the next result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos  <= {PW{1'b0}};
      zero <= 1'b0;
    end else if (state == ST_SCAN && hit_s) begin
      pos  <= hit_pos_s;
      zero <= 1'b0;
    end else if (state == ST_SCAN && last_s) begin
      pos  <= {PW{1'b0}};
      zero <= 1'b1;
    end else begin
      pos  <= pos;
      zero <= zero;
    end
  end

`ifdef LEAD_ONE_SCAN_NORM_EN
  logic [WIDTH-1:0] norm_s;

  // Normalised operand: the found bit is moved to the MSB (dir=1) or to the LSB (dir=0).
  always_comb begin
    if (dir_r) begin
      norm_s = data << (PW'(WIDTH - 1) - hit_pos_s);
    end else begin
      norm_s = data >> hit_pos_s;
    end
  end

  // norm_out is registered on the same edge as pos; an all-zero operand yields 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      norm_out <= {WIDTH{1'b0}};
    end else if (state == ST_SCAN && hit_s) begin
      norm_out <= norm_s;
    end else if (state == ST_SCAN && last_s) begin
      norm_out <= {WIDTH{1'b0}};
    end else begin
      norm_out <= norm_out;
    end
  end
`endif

endmodule

// File: tb/tb_lead_one_scan.sv
// Testbench for lead_one_scan (WIDTH=16, STEP=4, plus a STEP=16 instance).
// Expected results come from a bit-scan model and are queued when a request
// is driven. They are popped and compared when done is seen.
module tb_lead_one_scan;

  localparam int WIDTH  = 16;
  localparam int STEP   = 4;
  localparam int NCHUNK = WIDTH / STEP;

  typedef struct {
    logic [3:0]  pos;
    logic        zero;
    logic [15:0] norm;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic        dir;
  logic        busy, done, zero;
  logic [3:0]  pos;
  logic [15:0] norm_out;

  logic        start2;
  logic [15:0] din2;
  logic        dir2;
  logic        busy2, done2, zero2;
  logic [3:0]  pos2;
  logic [15:0] norm2;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [3:0]  last_pos = 4'd0;
  logic        last_zero = 1'b0;
  logic        prev_done = 1'b0;

  always #5 clk = ~clk;

  lead_one_scan #(.WIDTH(WIDTH), .STEP(STEP)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .dir(dir),
    .busy(busy), .done(done), .pos(pos), .zero(zero)
`ifdef LEAD_ONE_SCAN_NORM_EN
    , .norm_out(norm_out)
`endif
  );

  lead_one_scan #(.WIDTH(16), .STEP(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start2), .din(din2), .dir(dir2),
    .busy(busy2), .done(done2), .pos(pos2), .zero(zero2)
`ifdef LEAD_ONE_SCAN_NORM_EN
    , .norm_out(norm2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: plain bit scan, then derive chunk number and latency from it.
  function automatic exp_t model(input logic [15:0] d, input logic dr);
    exp_t e;
    int p;
    p = 0;
    if (dr) begin
      for (int i = 0; i < 16; i++) if (d[i]) p = i;
    end else begin
      for (int i = 15; i >= 0; i--) if (d[i]) p = i;
    end
    e.zero = (d == 16'h0000);
    e.pos  = e.zero ? 4'd0 : 4'(p);
    if (e.zero) begin
      e.norm = 16'h0000;
      e.cyc  = NCHUNK + 1;
    end else if (dr) begin
      e.norm = d << (15 - p);
      e.cyc  = (15 - p) / STEP + 2;
    end else begin
      e.norm = d >> p;
      e.cyc  = p / STEP + 2;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      check("done_one_cycle", 32'(prev_done), 32'(0));
      check("done_expected", 32'(q.size() > 0), 32'(1));
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check("pos", 32'(pos), 32'(mon_e.pos));
        check("zero", 32'(zero), 32'(mon_e.zero));
        check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("busy_at_done", 32'(busy), 32'(1));
`ifdef LEAD_ONE_SCAN_NORM_EN
        check("norm_out", 32'(norm_out), 32'(mon_e.norm));
`endif
        last_pos  = mon_e.pos;
        last_zero = mon_e.zero;
      end
    end
    prev_done = done;
  end

  // Drive one request from a negedge; hold = extra edges that keep start high.
  task automatic do_op(input logic [15:0] d, input logic dr, input int hold);
    exp_t e;
    int n;
    check("hold_pos", 32'(pos), 32'(last_pos));
    check("hold_zero", 32'(zero), 32'(last_zero));
    e = model(d, dr);
    start = 1'b1;
    din   = d;
    dir   = dr;
    @(posedge clk); #1;
    e.cyc = cyc + e.cyc - 1;
    q.push_back(e);
    check("busy_after_start", 32'(busy), 32'(1));
    repeat (hold) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    din   = 16'($urandom);
    dir   = ~dr;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 32'(q.size()), 32'(0));
      q.delete();
    end
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; din = 16'hFFFF; dir = 1'b1;
    start2 = 1'b0; din2 = 16'h0000; dir2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_pos", 32'(pos), 32'(0));
    check("rst_zero", 32'(zero), 32'(0));
`ifdef LEAD_ONE_SCAN_NORM_EN
    check("rst_norm", 32'(norm_out), 32'(0));
`endif
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h005A, 1'b1, 0);
    do_op(16'h005A, 1'b0, 0);
    do_op(16'h0000, 1'b1, 0);
    do_op(16'h8000, 1'b1, 2);
    do_op(16'h0001, 1'b1, 0);
    do_op(16'h8000, 1'b0, 0);
    do_op(16'hFFFF, 1'b1, 0);
    do_op(16'hFFFF, 1'b0, 0);
    do_op(16'h0000, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      do_op(16'($urandom) & 16'($urandom), 1'($urandom_range(0, 1)), 0);
    end
    do_op(16'h005A, 1'b1, 0);

    // Abort a scan with a one-edge reset; no done may follow.
    start = 1'b1; din = 16'h0001; dir = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_pos", 32'(pos), 32'(0));
    check("abort_zero", 32'(zero), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    last_pos = 4'd0;
    last_zero = 1'b0;
    repeat (8) @(negedge clk);
    do_op(16'h0010, 1'b0, 0);

    // Single-chunk instance: the whole operand is examined in one cycle.
    start2 = 1'b1; din2 = 16'h0006; dir2 = 1'b0;
    @(posedge clk); #1;
    check("s16_done_early", 32'(done2), 32'(0));
    check("s16_busy", 32'(busy2), 32'(1));
    @(negedge clk);
    start2 = 1'b0; din2 = 16'h8000; dir2 = 1'b1;
    @(posedge clk); #1;
    check("s16_done", 32'(done2), 32'(1));
    check("s16_pos", 32'(pos2), 32'(1));
    check("s16_zero", 32'(zero2), 32'(0));
    @(posedge clk); #1;
    check("s16_done_after", 32'(done2), 32'(0));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
